// File: rtl/mem_pkg.sv
// Shared definitions for the memory request/response interface.
//
// Contents:
//   mem_op_t       - request/response operation code (read or write)
//   MEM_*_BITS     - fixed widths of the address, data and strobe fields
//   strb_merge()   - byte-lane merge used for masked writes
//
// The request and response structs depend on the opaque-tag width, which
// each unit takes as a parameter. A package cannot be parameterized, so
// each user declares those structs locally from these field widths.
package mem_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_t;

  localparam int MEM_ADDR_BITS = 32;
  localparam int MEM_DATA_BITS = 32;
  localparam int MEM_STRB_BITS = MEM_DATA_BITS / 8;

  // Returns old_word with every byte lane enabled in strb replaced by new_word.
  function automatic logic [MEM_DATA_BITS-1:0] strb_merge(
    input logic [MEM_DATA_BITS-1:0] old_word,
    input logic [MEM_DATA_BITS-1:0] new_word,
    input logic [MEM_STRB_BITS-1:0] strb
  );
    logic [MEM_DATA_BITS-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MEM_STRB_BITS; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Generic in-order FIFO for response payloads.
//
// Parameters:
//   p_depth   - number of entries (any value >= 1)
//   t_payload - packed payload type stored per entry
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears pointers)
//   enq_val   - enqueue enq_data this cycle
//   enq_data  - payload to enqueue
//   deq       - dequeue the head this cycle (ignored when empty)
//   deq_data  - head entry; meaningful only while !empty
//   full      - all entries occupied
//   empty     - no entries occupied
//
// Enqueue while full is accepted only together with a dequeue, which frees
// the slot first. There is no bypass: an entry written into an empty FIFO
// becomes visible on the following cycle.
module mem_resp_fifo #(
  parameter int  p_depth   = 4,
  parameter type t_payload = logic [31:0]
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     enq_val,
  input  t_payload enq_data,
  input  logic     deq,
  output t_payload deq_data,
  output logic     full,
  output logic     empty
);

  localparam int IDX_BITS = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(p_depth - 1);

  t_payload            store [p_depth];
  logic [IDX_BITS-1:0] wr_idx, rd_idx;
  // Phase bits flip on every wrap so equal indices can be told apart as
  // full (phases differ) or empty (phases match), for any depth.
  logic                wr_ph, rd_ph;
  logic                do_enq, do_deq;

  assign empty    = (wr_idx == rd_idx) && (wr_ph == rd_ph);
  assign full     = (wr_idx == rd_idx) && (wr_ph != rd_ph);
  assign do_deq   = deq && !empty;
  assign do_enq   = enq_val && (!full || do_deq);
  assign deq_data = store[rd_idx];

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      wr_ph  <= 1'b0;
      rd_idx <= '0;
      rd_ph  <= 1'b0;
    end else begin
      if (do_enq) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx <= '0;
          wr_ph  <= !wr_ph;
        end else begin
          wr_idx <= wr_idx + IDX_BITS'(1);
        end
      end
      if (do_deq) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx <= '0;
          rd_ph  <= !rd_ph;
        end else begin
          rd_idx <= rd_idx + IDX_BITS'(1);
        end
      end
    end
  end

  // NOTE: entry storage carries no reset; validity is tracked by the
  // pointers alone, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_enq) store[wr_idx] <= enq_data;
  end

endmodule

// File: rtl/pipelined_mem_server.sv
// Responder end of the memory interface: word-addressed array with a fixed
// minimum response latency and in-order, backpressured responses.
//
// Parameters:
//   p_opaq_bits     - width of the client tag echoed in responses
//   p_num_words     - array depth in 32-bit words (power of two)
//   p_latency       - cycles from acceptance to earliest resp_val (>= 1)
//   p_max_in_flight - accepted-but-unconsumed response limit (>= p_latency)
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_*           - request channel (val/rdy, op, opaque, addr, data, strb)
//   resp_*          - response channel (val/rdy, op, opaque, addr, data)
module pipelined_mem_server
  import mem_pkg::*;
#(
  parameter int p_opaq_bits     = 8,
  parameter int p_num_words     = 256,
  parameter int p_latency       = 2,
  parameter int p_max_in_flight = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [3:0]             req_strb,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_addr,
  output logic [31:0]            resp_data
);

  localparam int IDX_BITS = $clog2(p_num_words);
  localparam int CNT_BITS = $clog2(p_max_in_flight + 1);

  typedef struct packed {
    mem_op_t                  op;
    logic [p_opaq_bits-1:0]   opaque;
    logic [MEM_ADDR_BITS-1:0] addr;
    logic [MEM_DATA_BITS-1:0] data;
  } t_resp;

  logic [MEM_DATA_BITS-1:0] mem [p_num_words];
  logic [IDX_BITS-1:0]      idx;
  logic [CNT_BITS-1:0]      cnt;
  logic                     req_fire, resp_fire;
  t_resp                    req_resp;
  logic                     enq_val;
  t_resp                    enq_data;
  t_resp                    head;
  logic                     fifo_full, fifo_empty;

  // Ready depends only on registered state, never on resp_rdy; counting
  // every accepted transaction guarantees the FIFO cannot overflow.
  assign req_rdy   = !rst && (cnt < CNT_BITS'(p_max_in_flight));
  assign req_fire  = req_val && req_rdy;
  assign resp_val  = !rst && !fifo_empty;
  assign resp_fire = resp_val && resp_rdy;
  assign idx       = req_addr[IDX_BITS+1:2];

  // Asynchronous read samples the array before this edge's write lands, and
  // a write accepted on the previous edge is already visible.
  always_comb begin
    req_resp.op     = mem_op_t'(req_op);
    req_resp.opaque = req_opaque;
    req_resp.addr   = req_addr;
    req_resp.data   = (req_op == MEM_WRITE) ? '0 : mem[idx];
  end

  // NOTE: the array is deliberately left out of reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (req_fire && (req_op == MEM_WRITE)) begin
      mem[idx] <= strb_merge(mem[idx], req_data, req_strb);
    end
  end

  // The FIFO register supplies one cycle of latency, so the shift pipeline
  // holds only p_latency-1 stages.
  generate
    if (p_latency == 1) begin : g_direct
      assign enq_val  = req_fire;
      assign enq_data = req_resp;
    end else begin : g_pipe
      localparam int STAGES = p_latency - 1;
      logic [STAGES-1:0] pipe_val;
      t_resp             pipe_data [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_val <= '0;
        end else begin
          pipe_val[0] <= req_fire;
          for (int i = 1; i < STAGES; i++) pipe_val[i] <= pipe_val[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pipe_data[0] <= req_resp;
        for (int i = 1; i < STAGES; i++) pipe_data[i] <= pipe_data[i-1];
      end

      assign enq_val  = pipe_val[STAGES-1];
      assign enq_data = pipe_data[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   cnt <= cnt + CNT_BITS'(1);
        2'b01:   cnt <= cnt - CNT_BITS'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  mem_resp_fifo #(
    .p_depth   (p_max_in_flight),
    .t_payload (t_resp)
  ) u_resp_fifo (
    .clk      (clk),
    .rst      (rst),
    .enq_val  (enq_val),
    .enq_data (enq_data),
    .deq      (resp_fire),
    .deq_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // The credit counter must keep the FIFO from ever refusing an entry.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_full && enq_val && !resp_fire));
  end

  assign resp_op     = head.op;
  assign resp_opaque = head.opaque;
  assign resp_addr   = head.addr;
  assign resp_data   = head.data;

endmodule

// File: tb/tb_pipelined_mem_server.sv
// Directed self-checking bench for pipelined_mem_server with default
// parameters. Inputs are driven and outputs sampled on the falling edge.
module tb_pipelined_mem_server;

  logic        clk;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_strb;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_op;
  logic [7:0]  resp_opaque;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  pipelined_mem_server dut (
    .clk         (clk),
    .rst         (rst),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_op      (req_op),
    .req_opaque  (req_opaque),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_strb    (req_strb),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_op     (resp_op),
    .resp_opaque (resp_opaque),
    .resp_addr   (resp_addr),
    .resp_data   (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_resp(input string tag, input logic op,
                            input logic [7:0] opq, input logic [31:0] addr,
                            input logic [31:0] data);
    check({tag, "_val"},  {31'd0, resp_val}, 32'd1);
    check({tag, "_op"},   {31'd0, resp_op},  {31'd0, op});
    check({tag, "_opq"},  {24'd0, resp_opaque}, {24'd0, opq});
    check({tag, "_addr"}, resp_addr, addr);
    check({tag, "_data"}, resp_data, data);
  endtask

  initial begin
    int   accepted;
    logic fire;

    rst = 1'b1; req_val = 1'b0; req_op = 1'b0; req_opaque = '0;
    req_addr = '0; req_data = '0; req_strb = '0; resp_rdy = 1'b1;

    // Reset behaviour
    @(negedge clk);
    check("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("rst_req_rdy",  {31'd0, req_rdy},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_rdy",  {31'd0, req_rdy},  32'd1);
    check("post_rst_resp_val", {31'd0, resp_val}, 32'd0);

    // Full-word write then read of the same address
    req_val = 1'b1; req_op = 1'b1; req_opaque = 8'h03;
    req_addr = 32'h10; req_data = 32'hDEADBEEF; req_strb = 4'hF;
    @(negedge clk);
    check("lat_not_early", {31'd0, resp_val}, 32'd0);
    req_op = 1'b0; req_opaque = 8'h04; req_addr = 32'h10; req_data = '0;
    @(negedge clk);
    check_resp("wr1", 1'b1, 8'h03, 32'h10, 32'h0);
    req_val = 1'b0;
    @(negedge clk);
    check_resp("rd1", 1'b0, 8'h04, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("idle1_resp_val", {31'd0, resp_val}, 32'd0);

    // Single-byte write, read back, aliased read
    req_val = 1'b1; req_op = 1'b1; req_opaque = 8'h05;
    req_addr = 32'h10; req_data = 32'h000000AA; req_strb = 4'h1;
    @(negedge clk);
    req_op = 1'b0; req_opaque = 8'h06; req_strb = 4'h0; req_data = '0;
    @(negedge clk);
    check_resp("wr2", 1'b1, 8'h05, 32'h10, 32'h0);
    req_opaque = 8'h07; req_addr = 32'h410;
    @(negedge clk);
    req_val = 1'b0;
    check_resp("rd2", 1'b0, 8'h06, 32'h10, 32'hDEADBEAA);
    @(negedge clk);
    check_resp("rd_alias", 1'b0, 8'h07, 32'h410, 32'hDEADBEAA);
    @(negedge clk);
    check("idle2_resp_val", {31'd0, resp_val}, 32'd0);

    // Backpressure: stream reads with resp_rdy low
    resp_rdy = 1'b0; req_val = 1'b1; req_op = 1'b0;
    req_addr = 32'h10; req_opaque = 8'h10; accepted = 0;
    for (int i = 0; i < 8; i++) begin
      fire = req_rdy;
      @(negedge clk);
      if (fire) begin
        accepted++;
        req_opaque = 8'h10 + 8'(accepted);
      end
    end
    check("bp_accepted", 32'(accepted), 32'd4);
    check("bp_req_rdy",  {31'd0, req_rdy}, 32'd0);
    check_resp("bp_head", 1'b0, 8'h10, 32'h10, 32'hDEADBEAA);
    req_val = 1'b0; resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_rdy_reassert", {31'd0, req_rdy}, 32'd1);
    check_resp("bp_r1", 1'b0, 8'h11, 32'h10, 32'hDEADBEAA);
    @(negedge clk);
    check_resp("bp_r2", 1'b0, 8'h12, 32'h10, 32'hDEADBEAA);
    @(negedge clk);
    check_resp("bp_r3", 1'b0, 8'h13, 32'h10, 32'hDEADBEAA);
    @(negedge clk);
    check("bp_drained", {31'd0, resp_val}, 32'd0);

    // Continuous reads: tags 0..15, one response per cycle
    for (int c = 0; c <= 18; c++) begin
      logic exp_val;
      exp_val = (c >= 2) && (c <= 17);
      check("stream_val", {31'd0, resp_val}, {31'd0, exp_val});
      if (exp_val) check("stream_opq", {24'd0, resp_opaque}, 32'(c - 2));
      if (c < 16) begin
        check("stream_rdy", {31'd0, req_rdy}, 32'd1);
        req_val = 1'b1; req_opaque = 8'(c); req_addr = 32'(c * 4);
      end else begin
        req_val = 1'b0;
      end
      @(negedge clk);
    end

    // Reset with three requests in flight
    resp_rdy = 1'b0; req_val = 1'b1; req_opaque = 8'h20; req_addr = 32'h10;
    @(negedge clk);
    req_opaque = 8'h21;
    @(negedge clk);
    req_opaque = 8'h22;
    @(negedge clk);
    req_val = 1'b0; rst = 1'b1;
    #1;
    check("inrst_resp_val", {31'd0, resp_val}, 32'd0);
    check("inrst_req_rdy",  {31'd0, req_rdy},  32'd0);
    @(negedge clk);
    check("rst2_resp_val", {31'd0, resp_val}, 32'd0);
    rst = 1'b0; resp_rdy = 1'b1;
    #1;
    check("rst2_cnt",     32'(dut.cnt), 32'd0);
    check("rst2_req_rdy", {31'd0, req_rdy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dropped_no_resp", {31'd0, resp_val}, 32'd0);
    end
    req_val = 1'b1; req_op = 1'b0; req_opaque = 8'h30; req_addr = 32'h10;
    @(negedge clk);
    req_val = 1'b0;
    check("post_rst_lat", {31'd0, resp_val}, 32'd0);
    @(negedge clk);
    check_resp("post_rst_rd", 1'b0, 8'h30, 32'h10, 32'hDEADBEAA);
    @(negedge clk);
    check("final_idle", {31'd0, resp_val}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
